// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the req/gnt/rvalid handshake to
// instruction memory and drives the IF/ID register, with a one-entry stall buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_rs1,
    output logic [4:0]  IF_ID_rs2
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        stall_s;
    logic [31:0] target_s;
    logic        deliver_s;
    logic [31:0] deliver_pc_s;
    logic [31:0] deliver_instr_s;

    assign stall_s  = ~pc_write | ~IF_ID_write;
    assign target_s = branch_target & 32'hFFFF_FFFC;

    // Fetch FSM: next state, PC update and instruction hand-off to IF/ID.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_pc_d        = req_pc_q;
        buf_pc_d        = buf_pc_q;
        buf_instr_d     = buf_instr_q;
        deliver_s       = 1'b0;
        deliver_pc_s    = 32'h0000_0000;
        deliver_instr_s = NOP_INSTR;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
                if (flush) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (flush) begin
                    pc_d = target_s;
                    if (imem_gnt) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (imem_gnt) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    pc_d = target_s;
                    if (imem_rvalid) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    if (!stall_s) begin
                        deliver_s       = 1'b1;
                        deliver_pc_s    = req_pc_q;
                        deliver_instr_s = imem_rdata;
                        pc_d            = req_pc_q + 32'd4;
                        state_d         = ST_FETCH;
                    end else begin
                        buf_pc_d    = req_pc_q;
                        buf_instr_d = imem_rdata;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = target_s;
                    state_d = ST_FETCH;
                end else if (!stall_s) begin
                    deliver_s       = 1'b1;
                    deliver_pc_s    = buf_pc_q;
                    deliver_instr_s = buf_instr_q;
                    pc_d            = buf_pc_q + 32'd4;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // IF/ID register: flush wins, then the write enable, then bubble insertion.
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (flush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (IF_ID_write) begin
            if (deliver_s) begin
                if_id_pc_d    = deliver_pc_s;
                if_id_instr_d = deliver_instr_s;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end else begin
            if_id_valid_d = if_id_valid_q;
        end
    end

    // State, PC, buffer and IF/ID flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            pc_q          <= RESET_PC;
            req_pc_q      <= 32'h0000_0000;
            buf_pc_q      <= 32'h0000_0000;
            buf_instr_q   <= NOP_INSTR;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // The request is decoded from state only, so gnt/rvalid/flush never reach it combinationally.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign IF_ID_pc    = if_id_pc_q;
    assign IF_ID_instr = if_id_instr_q;
    assign IF_ID_valid = if_id_valid_q;
    assign IF_ID_rs1   = if_id_instr_q[19:15];
    assign IF_ID_rs2   = if_id_instr_q[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small instruction memory model and hand-derived
// IF/ID and request-address expectations, sampled on the falling clock edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b1;
    logic        IF_ID_write = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] branch_target = 32'h0000_0000;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    int n_cmp = 0;
    int n_err = 0;

    // memory model state
    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] last_gnt = 32'hFFFF_FFFF;
    int          viol = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .IF_ID_write  (IF_ID_write),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_valid  (IF_ID_valid),
        .IF_ID_rs1    (IF_ID_rs1),
        .IF_ID_rs2    (IF_ID_rs2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h00A0_0093;
        return a ^ 32'h0123_4567;
    endfunction

    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend & rv_en;
    assign imem_rdata  = imem_rvalid ? instr_of(pend_addr) : 32'hDEAD_BEEF;

    // Instruction memory: one response per grant, released when rv_en allows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= 32'h0000_0000;
        end else begin
            if (imem_req && pend) viol <= viol + 1;
            if (imem_req && imem_gnt) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
                last_gnt  <= imem_addr;
            end else if (imem_rvalid) begin
                pend <= 1'b0;
            end
        end
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic valid);
        logic [31:0] w;
        w = instr;
        check32({tag, "_pc"}, IF_ID_pc, pc);
        check32({tag, "_instr"}, IF_ID_instr, instr);
        check32({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
        check32({tag, "_rs1"}, {27'd0, IF_ID_rs1}, {27'd0, w[19:15]});
        check32({tag, "_rs2"}, {27'd0, IF_ID_rs2}, {27'd0, w[24:20]});
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check32({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) check32({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        tick(); tick();
        check_req("rst", 1'b0, 32'h0);
        check32("rst_addr", imem_addr, 32'h0000_0100);
        check_ifid("rst", 32'h0, NOP, 1'b0);

        // release: RST cycle, then first request
        rst_n = 1'b1;
        #1 check_req("rel_rst", 1'b0, 32'h0);
        tick();
        check_req("first_req", 1'b1, 32'h0000_0100);

        // streaming: one instruction every second cycle, bubbles between
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'h0000_0100 + 32'(4 * k);
            tick();
            check32("bubble_valid", {31'd0, IF_ID_valid}, 32'd0);
            check32("bubble_instr", IF_ID_instr, NOP);
            check_req("wait", 1'b0, 32'h0);
            tick();
            check_ifid("stream", a, instr_of(a), 1'b1);
            check_req("stream_next", 1'b1, a + 32'd4);
        end

        // redirect to 0x1FC (low bits of target forced to zero) without a grant
        gnt_en = 1'b0; flush = 1'b1; branch_target = 32'h0000_01FE;
        tick();
        flush = 1'b0; gnt_en = 1'b1;
        check32("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
        check_req("redir", 1'b1, 32'h0000_01FC);
        tick(); tick();
        check_ifid("pre_stall", 32'h0000_01FC, instr_of(32'h0000_01FC), 1'b1);
        check_req("pre_stall", 1'b1, 32'h0000_0200);

        // stall three cycles while 0x200 is fetched and returned
        pc_write = 1'b0; IF_ID_write = 1'b0;
        tick();
        check_ifid("stall1", 32'h0000_01FC, instr_of(32'h0000_01FC), 1'b1);
        tick();
        check_ifid("stall2", 32'h0000_01FC, instr_of(32'h0000_01FC), 1'b1);
        check_req("hold", 1'b0, 32'h0);
        tick();
        check_ifid("stall3", 32'h0000_01FC, instr_of(32'h0000_01FC), 1'b1);
        pc_write = 1'b1; IF_ID_write = 1'b1;
        tick();
        check_ifid("unstall", 32'h0000_0200, 32'h00A0_0093, 1'b1);
        check_req("unstall", 1'b1, 32'h0000_0204);

        // flush while waiting on 0x300; response comes two cycles later
        gnt_en = 1'b0; flush = 1'b1; branch_target = 32'h0000_0300;
        tick();
        flush = 1'b0; gnt_en = 1'b1; rv_en = 1'b0;
        tick();
        check32("gnt_300", last_gnt, 32'h0000_0300);
        flush = 1'b1; branch_target = 32'h0000_0400;
        tick();
        flush = 1'b0;
        check32("drain_valid", {31'd0, IF_ID_valid}, 32'd0);
        check_req("drain", 1'b0, 32'h0);
        tick();
        rv_en = 1'b1;
        check32("drain2_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick();
        check32("dropped_valid", {31'd0, IF_ID_valid}, 32'd0);
        check_req("after_drain", 1'b1, 32'h0000_0400);
        tick();
        check32("gnt_400", last_gnt, 32'h0000_0400);
        tick();
        check_ifid("tgt400", 32'h0000_0400, instr_of(32'h0000_0400), 1'b1);

        // flush and rvalid together with IF_ID_write low
        tick();
        flush = 1'b1; branch_target = 32'h0000_0500; IF_ID_write = 1'b0;
        tick();
        flush = 1'b0; IF_ID_write = 1'b1;
        check_ifid("flush_rv", 32'h0000_0400, NOP, 1'b0);
        check_req("flush_rv", 1'b1, 32'h0000_0500);
        tick(); tick();
        check_ifid("tgt500", 32'h0000_0500, instr_of(32'h0000_0500), 1'b1);

        // PC wrap
        gnt_en = 1'b0; flush = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0; gnt_en = 1'b1;
        check_req("top", 1'b1, 32'hFFFF_FFFC);
        tick(); tick();
        check_ifid("top", 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC), 1'b1);
        check_req("wrap", 1'b1, 32'h0000_0000);

        // asynchronous reset while holding a buffered response
        pc_write = 1'b0;
        tick(); tick();
        check_req("in_hold", 1'b0, 32'h0);
        check32("in_hold_pc", IF_ID_pc, 32'hFFFF_FFFC);
        #2 rst_n = 1'b0;
        #1;
        check_req("arst", 1'b0, 32'h0);
        check32("arst_addr", imem_addr, 32'h0000_0100);
        check_ifid("arst", 32'h0, NOP, 1'b0);
        pc_write = 1'b1;
        tick();
        rst_n = 1'b1;
        #1 check_req("rel2_rst", 1'b0, 32'h0);
        tick();
        check_req("rel2_first", 1'b1, 32'h0000_0100);
        tick(); tick();
        check_ifid("rel2", 32'h0000_0100, instr_of(32'h0000_0100), 1'b1);

        check32("one_outstanding", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
